// File: rtl/bridge_utils_pkg.sv
// Shared AXI-to-APB bridge types: burst descriptor, burst/response encodings
// and the per-beat address step used by the read and write engines.
package bridge_utils;

  localparam int MAX_ADDR_WIDTH = 64;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef struct packed {
    logic [MAX_ADDR_WIDTH-1:0] addr;
    logic [3:0]                len;
    logic [2:0]                size;
    burst_t                    burst;
  } addr_info_t;

  function automatic logic wrap_len_ok(input logic [3:0] len);
    return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
  endfunction

  // Reserved bursts and WRAP with a non power-of-two beat count run as INCR with SLVERR.
  function automatic logic desc_illegal(input addr_info_t d);
    return (d.burst == BURST_RSVD) || ((d.burst == BURST_WRAP) && !wrap_len_ok(d.len));
  endfunction

  function automatic logic [MAX_ADDR_WIDTH-1:0] beat_addr_next(input addr_info_t d);
    logic [MAX_ADDR_WIDTH-1:0] step;
    logic [MAX_ADDR_WIDTH-1:0] wrap_mask;
    logic [MAX_ADDR_WIDTH-1:0] nxt;
    step      = MAX_ADDR_WIDTH'(1) << d.size;
    wrap_mask = ((MAX_ADDR_WIDTH'(d.len) + MAX_ADDR_WIDTH'(1)) << d.size) - MAX_ADDR_WIDTH'(1);
    nxt       = d.addr + step;
    if (d.burst == BURST_FIXED) begin
      nxt = d.addr;
    end else if ((d.burst == BURST_WRAP) && wrap_len_ok(d.len)) begin
      nxt = (d.addr & ~wrap_mask) | (nxt & wrap_mask);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rd_beat_fifo.sv
// Read-beat buffer: synchronous FIFO, head readable the cycle after push.
// Push ignored when full, pop ignored when empty; push+pop together keeps count.
module rd_beat_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == CNT_W'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/apb_read_master.sv
// AXI read burst -> single APB reads; start to SETUP 1 cycle, 2 cycles/beat, beats buffered in a FIFO.
// Stalls in WAIT_SPACE while the FIFO is full. APB_TIMEOUT_EN adds a per-beat ACCESS timeout.
module apb_read_master
  import bridge_utils::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [3:0]            len,
  input  logic [2:0]            size,
  input  logic [1:0]            burst,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] beat_data,
  output logic [1:0]            beat_resp,
  output logic                  beat_valid,
  input  logic                  beat_pop,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  pslverr
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int FW    = DATA_WIDTH + 2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, WAIT_SPACE} state_t;

  state_t           state_q, state_d;
  addr_info_t       desc_q, desc_d;
  logic [3:0]       beat_cnt_q, beat_cnt_d;
  logic             fifo_pop, fifo_full, fifo_empty, space_after;
  logic [CNT_W-1:0] fifo_count;
  logic [FW-1:0]    push_dat, head_dat;
  logic             beat_done, beat_err, tmo_hit;
  logic [DATA_WIDTH-1:0] beat_rdata;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_hit = (state_q == ACCESS) && !pready && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_cnt_d = '0;
    if ((state_q == ACCESS) && !pready && !tmo_hit) tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_cnt_q <= '0;
    else        tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit        = 1'b0;
`endif

  assign beat_done  = (state_q == ACCESS) && (pready || tmo_hit);
  assign beat_err   = pslverr || tmo_hit || desc_illegal(desc_q);
  assign beat_rdata = tmo_hit ? '0 : prdata;
  assign push_dat   = {(beat_err ? RESP_SLVERR : RESP_OKAY), beat_rdata};
  assign fifo_pop   = beat_pop && !fifo_empty;
  // The FIFO is never full in ACCESS, so after this push a slot remains unless count hits DEPTH.
  assign space_after = (fifo_count < CNT_W'(FIFO_DEPTH - 1)) || fifo_pop;

  rd_beat_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (beat_done),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign busy       = (state_q != IDLE) || !fifo_empty;
  assign beat_valid = !fifo_empty;
  assign beat_data  = head_dat[DATA_WIDTH-1:0];
  assign beat_resp  = head_dat[FW-1:DATA_WIDTH];
  assign paddr      = ADDR_WIDTH'(desc_q.addr);
  assign pwrite     = 1'b0;

  always_comb begin
    state_d    = state_q;
    desc_d     = desc_q;
    beat_cnt_d = beat_cnt_q;
    psel       = 1'b0;
    penable    = 1'b0;
    done       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !busy) begin
          desc_d.addr  = MAX_ADDR_WIDTH'(addr);
          desc_d.len   = len;
          desc_d.size  = size;
          desc_d.burst = burst_t'(burst);
          beat_cnt_d   = '0;
          state_d      = fifo_full ? WAIT_SPACE : SETUP;
        end
      end
      WAIT_SPACE: begin
        if (!fifo_full) state_d = SETUP;
      end
      SETUP: begin
        psel    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (beat_done) begin
          desc_d.addr = MAX_ADDR_WIDTH'(ADDR_WIDTH'(beat_addr_next(desc_q)));
          beat_cnt_d  = beat_cnt_q + 4'd1;
          if (beat_cnt_q == desc_q.len) begin
            done    = 1'b1;
            state_d = IDLE;
          end else if (tmo_hit || !space_after) begin
            // After a timeout WAIT_SPACE also gives the slave one deselected cycle.
            state_d = WAIT_SPACE;
          end else begin
            state_d = SETUP;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      desc_q     <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      desc_q     <= desc_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

endmodule
